// File: rtl/trade_order_ctrl.sv
// rtl/trade_order_ctrl.sv - sequences buy/sell decisions into single orders
// with a position-limit check, post-fill cooldown and order timeout.
module trade_order_ctrl #(
  parameter int POS_WIDTH = 8,
  parameter int POS_LIMIT = 8,
  parameter int ORDER_QTY = 1,
  parameter int COOLDOWN  = 4,
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 signal_valid,
  input  logic                 buy_signal,
  input  logic                 sell_signal,
  input  logic                 order_ready,
  output logic                 order_valid,
  output logic                 order_side,
  output logic [POS_WIDTH-1:0] order_qty,
  output logic [POS_WIDTH-1:0] position,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] reject_cnt,
  output logic [CNT_WIDTH-1:0] timeout_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, COOL} state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CW-1:0]               COOL_LOAD = CW'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
  localparam logic [TW-1:0]               WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [POS_WIDTH-1:0]        QTY_OUT   = POS_WIDTH'(ORDER_QTY);
  localparam logic signed [POS_WIDTH:0]   QTY_EXT   = (POS_WIDTH + 1)'(ORDER_QTY);
  localparam logic signed [POS_WIDTH:0]   LIM_EXT   = (POS_WIDTH + 1)'(POS_LIMIT);

  state_t                  state, state_nx;
  logic [TW-1:0]           wait_cnt, wait_nx;
  logic [CW-1:0]           cool_cnt, cool_nx;
  logic                    side_nx;
  logic [POS_WIDTH-1:0]    pos_nx;
  logic                    rej_inc, to_inc;
  logic signed [POS_WIDTH:0] pos_ext, pos_up, pos_dn;
  logic                    buy_ok, sell_ok;

  // One extra bit of headroom so the limit compare can never wrap.
  assign pos_ext = {position[POS_WIDTH-1], position};
  assign pos_up  = pos_ext + QTY_EXT;
  assign pos_dn  = pos_ext - QTY_EXT;
  assign buy_ok  = (pos_up <= LIM_EXT);
  assign sell_ok = (pos_dn >= -LIM_EXT);

  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    cool_nx  = cool_cnt;
    side_nx  = order_side;
    pos_nx   = position;
    rej_inc  = 1'b0;
    to_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (enable && signal_valid) begin
          if (buy_signal && sell_signal) begin
            rej_inc = 1'b1;
          end else if (buy_signal) begin
            if (buy_ok) begin
              state_nx = ISSUE;
              side_nx  = 1'b1;
              wait_nx  = '0;
            end else begin
              rej_inc = 1'b1;
            end
          end else if (sell_signal) begin
            if (sell_ok) begin
              state_nx = ISSUE;
              side_nx  = 1'b0;
              wait_nx  = '0;
            end else begin
              rej_inc = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        // A ready on the final wait cycle still counts as a fill.
        if (order_ready) begin
          pos_nx = order_side ? pos_up[POS_WIDTH-1:0] : pos_dn[POS_WIDTH-1:0];
          if (COOLDOWN == 0) begin
            state_nx = IDLE;
          end else begin
            state_nx = COOL;
            cool_nx  = COOL_LOAD;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = IDLE;
          to_inc   = 1'b1;
        end else begin
          wait_nx = wait_cnt + 1'b1;
        end
      end
      COOL: begin
        if (cool_cnt == '0) state_nx = IDLE;
        else                cool_nx  = cool_cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cool_cnt    <= '0;
      order_valid <= 1'b0;
      order_side  <= 1'b0;
      order_qty   <= '0;
      position    <= '0;
      busy        <= 1'b0;
      reject_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= wait_nx;
      cool_cnt    <= cool_nx;
      order_valid <= (state_nx == ISSUE);
      order_side  <= side_nx;
      order_qty   <= (state_nx == ISSUE) ? QTY_OUT : '0;
      position    <= pos_nx;
      busy        <= (state_nx != IDLE);
      if (rej_inc && (reject_cnt != '1))  reject_cnt  <= reject_cnt + 1'b1;
      if (to_inc && (timeout_cnt != '1))  timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_trade_order_ctrl.sv
// tb/tb_trade_order_ctrl.sv - self-checking bench for trade_order_ctrl
module tb_trade_order_ctrl;
  localparam int POS_WIDTH = 8;
  localparam int POS_LIMIT = 2;
  localparam int ORDER_QTY = 1;
  localparam int COOLDOWN  = 4;
  localparam int TIMEOUT   = 16;
  localparam int CNT_WIDTH = 4;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic clk = 1'b0;
  logic rst, enable, signal_valid, buy_signal, sell_signal, order_ready;
  logic                 order_valid, order_side, busy;
  logic [POS_WIDTH-1:0] order_qty, position;
  logic [CNT_WIDTH-1:0] reject_cnt, timeout_cnt;

  trade_order_ctrl #(
    .POS_WIDTH(POS_WIDTH), .POS_LIMIT(POS_LIMIT), .ORDER_QTY(ORDER_QTY),
    .COOLDOWN(COOLDOWN), .TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .signal_valid(signal_valid),
    .buy_signal(buy_signal), .sell_signal(sell_signal), .order_ready(order_ready),
    .order_valid(order_valid), .order_side(order_side), .order_qty(order_qty),
    .position(position), .busy(busy), .reject_cnt(reject_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic e, sv, b, s, r;
    logic v, side;
    int   pos;
    logic bsy;
    int   rej, to;
  } vec_t;
  vec_t tbl[$];

  // Reference model state: an open order, its wait time, remaining cooldown.
  int m_open, m_waited, m_cool, m_pos, m_rej, m_to, m_side;

  task automatic chk(input string name, input logic signed [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input int v, input int side, input int pos,
                           input int bsy, input int rej, input int to);
    chk({tag, ".order_valid"}, order_valid, v);
    if (v != 0) chk({tag, ".order_side"}, order_side, side);
    chk({tag, ".order_qty"}, $signed(order_qty), (v != 0) ? ORDER_QTY : 0);
    chk({tag, ".position"}, $signed(position), pos);
    chk({tag, ".busy"}, busy, bsy);
    chk({tag, ".reject_cnt"}, reject_cnt, rej);
    chk({tag, ".timeout_cnt"}, timeout_cnt, to);
  endtask

  task automatic drive(input logic e, input logic sv, input logic b, input logic s, input logic r);
    enable = e; signal_valid = sv; buy_signal = b; sell_signal = s; order_ready = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tv(input logic e, input logic sv, input logic b, input logic s, input logic r,
                    input logic v, input logic side, input int pos, input logic bsy,
                    input int rej, input int to);
    vec_t t;
    t.e = e; t.sv = sv; t.b = b; t.s = s; t.r = r;
    t.v = v; t.side = side; t.pos = pos; t.bsy = bsy; t.rej = rej; t.to = to;
    tbl.push_back(t);
  endtask

  task automatic model_step(input int rs, input int e, input int sv, input int b,
                            input int s, input int r);
    if (rs != 0) begin
      m_open = 0; m_waited = 0; m_cool = 0; m_pos = 0; m_rej = 0; m_to = 0; m_side = 0;
    end else if (m_open != 0) begin
      if (r != 0) begin
        m_pos  = m_pos + ((m_side != 0) ? ORDER_QTY : -ORDER_QTY);
        m_open = 0;
        m_cool = COOLDOWN;
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT) begin
          m_open = 0;
          if (m_to < CNT_MAX) m_to++;
        end
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (e != 0 && sv != 0) begin
      if (b != 0 && s != 0) begin
        if (m_rej < CNT_MAX) m_rej++;
      end else if (b != 0) begin
        if (m_pos + ORDER_QTY <= POS_LIMIT) begin
          m_open = 1; m_side = 1; m_waited = 0;
        end else if (m_rej < CNT_MAX) m_rej++;
      end else if (s != 0) begin
        if (m_pos - ORDER_QTY >= -POS_LIMIT) begin
          m_open = 1; m_side = 0; m_waited = 0;
        end else if (m_rej < CNT_MAX) m_rej++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check_out("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Fill, cooldown, conflict, limit, then sell back down.
    tv(1,1,1,0,1, 1,1,0,1,0,0);
    tv(0,0,0,0,1, 0,0,1,1,0,0);
    tv(1,1,1,0,0, 0,0,1,1,0,0);
    tv(0,0,0,0,0, 0,0,1,1,0,0);
    tv(1,1,0,1,0, 0,0,1,1,0,0);
    tv(0,0,0,0,0, 0,0,1,0,0,0);
    tv(1,1,1,1,0, 0,0,1,0,1,0);
    tv(1,1,1,0,1, 1,1,1,1,1,0);
    tv(0,0,0,0,1, 0,0,2,1,1,0);
    tv(0,0,0,0,0, 0,0,2,1,1,0);
    tv(0,0,0,0,0, 0,0,2,1,1,0);
    tv(0,0,0,0,0, 0,0,2,1,1,0);
    tv(0,0,0,0,0, 0,0,2,0,1,0);
    tv(1,1,1,0,0, 0,0,2,0,2,0);
    tv(1,1,0,1,0, 1,0,2,1,2,0);
    tv(0,1,1,0,0, 1,0,2,1,2,0);
    tv(0,0,0,0,1, 0,0,1,1,2,0);
    tv(0,0,0,0,0, 0,0,1,1,2,0);
    tv(0,0,0,0,0, 0,0,1,1,2,0);
    tv(0,0,0,0,0, 0,0,1,1,2,0);
    tv(0,0,0,0,0, 0,0,1,0,2,0);
    tv(0,1,1,0,0, 0,0,1,0,2,0);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].e, tbl[i].sv, tbl[i].b, tbl[i].s, tbl[i].r);
      check_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].side, tbl[i].pos,
                tbl[i].bsy, tbl[i].rej, tbl[i].to);
    end

    // Timeout: valid high exactly TIMEOUT cycles, then dropped with no cooldown.
    drive(1, 1, 1, 0, 0);
    check_out("to_accept", 1, 1, 1, 1, 2, 0);
    for (int i = 1; i < TIMEOUT; i++) begin
      drive(0, 0, 0, 0, 0);
      check_out($sformatf("to_wait%0d", i), 1, 1, 1, 1, 2, 0);
    end
    drive(0, 0, 0, 0, 0);
    check_out("to_drop", 0, 0, 1, 0, 2, 1);

    // Ready on the last wait cycle is a fill.
    drive(1, 1, 1, 0, 0);
    check_out("late_accept", 1, 1, 1, 1, 2, 1);
    for (int i = 1; i < TIMEOUT; i++) drive(0, 0, 0, 0, 0);
    check_out("late_pre", 1, 1, 1, 1, 2, 1);
    drive(0, 0, 0, 0, 1);
    check_out("late_fill", 0, 0, 2, 1, 2, 1);
    for (int i = 0; i < COOLDOWN; i++) drive(0, 0, 0, 0, 0);
    check_out("late_idle", 0, 0, 2, 0, 2, 1);

    // Back-pressure with conflict pulses during ISSUE and COOL.
    drive(1, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 1, 0);
      check_out($sformatf("bp%0d", i), 1, 0, 2, 1, 2, 1);
    end
    drive(1, 1, 1, 1, 1);
    check_out("bp_fill", 0, 0, 1, 1, 2, 1);
    for (int i = 0; i < COOLDOWN; i++) drive(1, 1, 1, 1, 0);
    check_out("bp_cool", 0, 0, 1, 0, 2, 1);

    // Reset in ISSUE aborts without a fill even with ready high.
    drive(1, 1, 1, 0, 0);
    check_out("rst_issue", 1, 1, 1, 1, 2, 1);
    rst = 1'b1;
    drive(0, 0, 0, 0, 1);
    check_out("rst_abort", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Reject counter saturates.
    for (int i = 0; i < CNT_MAX + 3; i++) drive(1, 1, 1, 1, 0);
    check_out("rej_sat", 0, 0, 0, 0, CNT_MAX, 0);

    // Randomized run against the reference model.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      int rs, e, sv, b, s, r;
      rs = ($urandom_range(0, 299) == 0) ? 1 : 0;
      e  = ($urandom_range(0, 9) < 8) ? 1 : 0;
      sv = $urandom_range(0, 1);
      b  = $urandom_range(0, 1);
      s  = $urandom_range(0, 1);
      r  = ($urandom_range(0, 99) < 12) ? 1 : 0;
      rst = rs[0];
      model_step(rs, e, sv, b, s, r);
      drive(e[0], sv[0], b[0], s[0], r[0]);
      check_out($sformatf("rnd%0d", n), m_open, m_side, m_pos,
                (m_open != 0 || m_cool > 0) ? 1 : 0, m_rej, m_to);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
